// File: rtl/tx_packet_arbiter.sv
// Packet-atomic round-robin arbiter sharing one TX stream between NUM_REQ packet sources.
// Optional build macro TX_ARB_PRIO0_EN gives requester 0 strict priority at arbitration.
module tx_packet_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_sop,
    input  logic [NUM_REQ-1:0]            req_eop,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_sop,
    output logic                          tx_eop,
    input  logic                          tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [15:0]                   pkts_sent,
    output logic                          proto_err
);

    localparam int IW = $clog2(NUM_REQ);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_XFER = 1'b1;

    logic          state_q, state_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [15:0]   pkts_q, pkts_d;
    logic          err_q, err_d;
    logic          mid_q, mid_d;

    logic [NUM_REQ-1:0]    cand;
    logic                  found;
    logic [IW-1:0]         winner;
    logic [IW-1:0]         grant_inc;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Circular search starting at the round-robin pointer; first hit wins.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        cand   = req_valid & req_sop;
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_q) + i) % NUM_REQ;
            if (!found && cand[IW'(idx)]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
`ifdef TX_ARB_PRIO0_EN
        if (cand[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
    end

    assign grant_inc = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        pkts_d    = pkts_q;
        err_d     = err_q;
        mid_d     = mid_q;
        req_ready = '0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_sop    = 1'b0;
        tx_eop    = 1'b0;

        if (state_q == ST_IDLE) begin
            // Stray non-SOP beats are swallowed here so they cannot block their source.
            req_ready = req_valid & ~req_sop;
            if (|(req_valid & ~req_sop)) begin
                err_d = 1'b1;
            end
            if (found) begin
                grant_d = winner;
                state_d = ST_XFER;
                mid_d   = 1'b0;
            end
        end else begin
            tx_valid           = req_valid[grant_q];
            tx_data            = data_arr[grant_q];
            tx_sop             = req_sop[grant_q];
            tx_eop             = req_eop[grant_q];
            req_ready[grant_q] = tx_ready;
            if (tx_valid && tx_ready) begin
                mid_d = 1'b1;
                if (mid_q && tx_sop) begin
                    err_d = 1'b1;
                end
                if (tx_eop) begin
                    state_d = ST_IDLE;
                    pkts_d  = pkts_q + 16'd1;
`ifdef TX_ARB_PRIO0_EN
                    if (grant_q != '0) begin
                        rr_d = grant_inc;
                    end
`else
                    rr_d = grant_inc;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            pkts_q  <= '0;
            err_q   <= 1'b0;
            mid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            pkts_q  <= pkts_d;
            err_q   <= err_d;
            mid_q   <= mid_d;
        end
    end

    assign grant_id  = grant_q;
    assign busy      = (state_q == ST_XFER);
    assign pkts_sent = pkts_q;
    assign proto_err = err_q;

endmodule
